// File: rtl/aux_arbiter.sv
// Shares one AUX channel engine between the link-training port (0) and the software
// register port (1): round-robin with per-port lock, automatic retry and a minimum idle gap.
module aux_arbiter #(
  parameter int unsigned RETRIES = 3,
  parameter int unsigned GAP     = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [19:0] r0addr,
  input  logic [7:0]  r0wdata,
  input  logic        r0req,
  input  logic        r0wr,
  input  logic        r0lock,
  output logic        r0ack,
  output logic        r0err,
  output logic [7:0]  r0rdata,
  input  logic [19:0] r1addr,
  input  logic [7:0]  r1wdata,
  input  logic        r1req,
  input  logic        r1wr,
  input  logic        r1lock,
  output logic        r1ack,
  output logic        r1err,
  output logic [7:0]  r1rdata,
  output logic [19:0] auxaddr,
  output logic [7:0]  auxwdata,
  output logic        auxreq,
  output logic        auxwr,
  input  logic        auxack,
  input  logic        auxerr,
  input  logic [7:0]  auxrdata,
  output logic        owner,
  output logic        busy,
  output logic [15:0] errcnt
);

  localparam int unsigned GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  state_t        r_state;
  logic          r_lastGnt;
  logic [2:0]    r_tries;
  logic [GW-1:0] r_gapCnt;
  logic          r_retry;

  logic w_ownerLock;
  logic w_grant;
  logic w_grantPort;
  logic w_lockedGrant;

  // A locked owner excludes the other port entirely; otherwise ties go to the port
  // that was not granted last.
  always_comb begin
    w_ownerLock   = owner ? r1lock : r0lock;
    w_grant       = 1'b0;
    w_grantPort   = owner;
    w_lockedGrant = 1'b0;
    if (w_ownerLock) begin
      if (owner ? r1req : r0req) begin
        w_grant       = 1'b1;
        w_grantPort   = owner;
        w_lockedGrant = 1'b1;
      end
    end else if (r0req && r1req) begin
      w_grant     = 1'b1;
      w_grantPort = ~r_lastGnt;
    end else if (r0req) begin
      w_grant     = 1'b1;
      w_grantPort = 1'b0;
    end else if (r1req) begin
      w_grant     = 1'b1;
      w_grantPort = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_lastGnt <= 1'b1;
      r_tries   <= 3'd0;
      r_gapCnt  <= '0;
      r_retry   <= 1'b0;
      auxreq    <= 1'b0;
      auxaddr   <= 20'd0;
      auxwdata  <= 8'd0;
      auxwr     <= 1'b0;
      owner     <= 1'b0;
      busy      <= 1'b0;
      r0ack     <= 1'b0;
      r0err     <= 1'b0;
      r1ack     <= 1'b0;
      r1err     <= 1'b0;
      r0rdata   <= 8'd0;
      r1rdata   <= 8'd0;
      errcnt    <= 16'd0;
    end else begin
      r0ack <= 1'b0;
      r0err <= 1'b0;
      r1ack <= 1'b0;
      r1err <= 1'b0;

      // Every engine failure is counted, retried or not.
      if (auxerr && errcnt != 16'hFFFF) begin
        errcnt <= errcnt + 16'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            owner <= w_grantPort;
            if (!w_lockedGrant) begin
              r_lastGnt <= w_grantPort;
            end
            auxaddr  <= w_grantPort ? r1addr  : r0addr;
            auxwdata <= w_grantPort ? r1wdata : r0wdata;
            auxwr    <= w_grantPort ? r1wr    : r0wr;
            r_tries  <= 3'd0;
            r_retry  <= 1'b0;
            auxreq   <= 1'b1;
            busy     <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (auxack) begin
            if (owner) begin
              r1rdata <= auxrdata;
              r1ack   <= 1'b1;
            end else begin
              r0rdata <= auxrdata;
              r0ack   <= 1'b1;
            end
            auxreq   <= 1'b0;
            r_retry  <= 1'b0;
            r_gapCnt <= GW'(GAP);
            r_state  <= S_GAP;
          end else if (auxerr) begin
            auxreq   <= 1'b0;
            r_gapCnt <= GW'(GAP);
            r_state  <= S_GAP;
            if (r_tries < 3'(RETRIES)) begin
              r_tries <= r_tries + 3'd1;
              r_retry <= 1'b1;
            end else begin
              r_retry <= 1'b0;
              if (owner) begin
                r1err <= 1'b1;
              end else begin
                r0err <= 1'b1;
              end
            end
          end
        end

        S_GAP: begin
          r_gapCnt <= r_gapCnt - GW'(1);
          // Retries reuse the latched fields and skip arbitration entirely.
          if (r_gapCnt <= GW'(1)) begin
            r_gapCnt <= '0;
            if (r_retry) begin
              auxreq  <= 1'b1;
              r_state <= S_ISSUE;
            end else begin
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end

        default: begin
          auxreq  <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aux_arbiter.sv
// Self-checking bench for aux_arbiter: directed table of single transactions, hand-written
// arbitration/lock/reset sequences and a randomized phase against a transaction-level model.
module tb_aux_arbiter;

  localparam int TB_RETRIES = 3;
  localparam int TB_GAP     = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic [19:0] r0addr, r1addr;
  logic [7:0]  r0wdata, r1wdata;
  logic        r0req, r1req, r0wr, r1wr, r0lock, r1lock;
  logic        r0ack, r1ack, r0err, r1err;
  logic [7:0]  r0rdata, r1rdata;
  logic [19:0] auxaddr;
  logic [7:0]  auxwdata;
  logic        auxreq, auxwr;
  logic        auxack = 1'b0;
  logic        auxerr = 1'b0;
  logic [7:0]  auxrdata = 8'h00;
  logic        owner, busy;
  logic [15:0] errcnt;

  aux_arbiter #(.RETRIES(TB_RETRIES), .GAP(TB_GAP)) dut (
    .clk(clk), .resetn(resetn),
    .r0addr(r0addr), .r0wdata(r0wdata), .r0req(r0req), .r0wr(r0wr), .r0lock(r0lock),
    .r0ack(r0ack), .r0err(r0err), .r0rdata(r0rdata),
    .r1addr(r1addr), .r1wdata(r1wdata), .r1req(r1req), .r1wr(r1wr), .r1lock(r1lock),
    .r1ack(r1ack), .r1err(r1err), .r1rdata(r1rdata),
    .auxaddr(auxaddr), .auxwdata(auxwdata), .auxreq(auxreq), .auxwr(auxwr),
    .auxack(auxack), .auxerr(auxerr), .auxrdata(auxrdata),
    .owner(owner), .busy(busy), .errcnt(errcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic        wr;
    int          nErr;
    logic        both;
    int          lat;
    logic [7:0]  engData;
    int          expAck;
    int          expErr;
    int          expAttempts;
    logic [15:0] expErrcnt;
    logic [7:0]  expRdata;
  } vec_t;

  typedef struct {
    int         code;
    logic [7:0] data;
  } engRsp_t;

  int nChecks = 0;
  int nFails  = 0;

  // Engine model state: scripted responses (0 ack, 1 err, 2 ack+err) or random mode.
  int          engScript[$];
  engRsp_t     engLog[$];
  logic        engMode = 1'b0;
  logic        engActive = 1'b0;
  int          engLatency = 1;
  int          engCnt = 0;
  int          engCode = 0;
  int          engRoll = 0;
  logic [7:0]  engData = 8'h00;

  // Observation logs and the transaction-level reference model.
  logic        ownerLog[$];
  logic [19:0] addrLog[$];
  logic [7:0]  wdataLog[$];
  logic        wrLog[$];
  int          gapLog[$];
  int unsigned riseCycleLog[$];
  int unsigned cycleCnt = 0;
  int unsigned lastReqCycle[2] = '{0, 0};
  int          respAckCnt[2] = '{0, 0};
  int          respErrCnt[2] = '{0, 0};
  logic        prevAuxreq = 1'b0;
  logic        sawCompletion = 1'b0;
  int          lowRun = 0;
  logic        sReq0 = 1'b0;
  logic        sReq1 = 1'b0;
  logic        modelOn = 1'b0;
  logic        mInTxn = 1'b0;
  logic        mLast = 1'b1;
  logic        mOwner = 1'b0;
  logic [15:0] mErrcnt = 16'd0;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic setReq(input int port, input logic v, input logic [19:0] a,
                        input logic [7:0] d, input logic w);
    if (port == 0) begin
      r0req = v; r0addr = a; r0wdata = d; r0wr = w;
    end else begin
      r1req = v; r1addr = a; r1wdata = d; r1wr = w;
    end
  endtask

  // Holds req until the port sees ack/err (res 0/1), or gives up after a bound (res 2).
  task automatic portTxn(input int port, input logic [19:0] a, input logic [7:0] d,
                         input logic w, output int res);
    res = 2;
    setReq(port, 1'b1, a, d, w);
    lastReqCycle[port] = cycleCnt;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (port == 0 ? r0ack : r1ack) begin res = 0; break; end
      if (port == 0 ? r0err : r1err) begin res = 1; break; end
    end
    setReq(port, 1'b0, a, d, w);
  endtask

  task automatic clearInputs();
    setReq(0, 1'b0, 20'd0, 8'd0, 1'b0);
    setReq(1, 1'b0, 20'd0, 8'd0, 1'b0);
    r0lock = 1'b0;
    r1lock = 1'b0;
    engScript.delete();
    engLatency = 1;
  endtask

  task automatic resetDut();
    resetn = 1'b0;
    clearInputs();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // Walks the engine responses since the last completion: errors until an ack, or until
  // RETRIES+1 errors exhaust the retries.
  task automatic modelCompletion();
    int         nErr;
    logic       expAckK;
    logic [7:0] expRd;
    engRsp_t    e;
    nErr = 0; expAckK = 1'b0; expRd = 8'h00;
    while (engLog.size() > 0) begin
      e = engLog.pop_front();
      if (e.code != 1) begin expAckK = 1'b1; expRd = e.data; break; end
      nErr++;
      if (nErr == TB_RETRIES + 1) break;
    end
    checkOutput("rnd_port", r1ack || r1err, mOwner);
    checkOutput("rnd_kind", r0ack || r1ack, expAckK);
    if (expAckK) checkOutput("rnd_rdata", r1ack ? r1rdata : r0rdata, expRd);
    checkOutput("rnd_errcnt", errcnt, mErrcnt);
  endtask

  always @(posedge clk) begin
    cycleCnt++;
    sReq0 = r0req;
    sReq1 = r1req;
  end

  // AUX engine: answers each auxreq after a latency, logging what it returned.
  always @(negedge clk) begin
    auxack = 1'b0;
    auxerr = 1'b0;
    if (!resetn || !auxreq) begin
      engActive = 1'b0;
    end else begin
      if (!engActive) begin
        engActive = 1'b1;
        engCnt = engMode ? int'($urandom_range(0, 3)) : engLatency;
      end
      if (engCnt == 0) begin
        if (engMode) begin
          engRoll = int'($urandom_range(0, 9));
          engCode = (engRoll < 6) ? 0 : (engRoll < 9) ? 1 : 2;
          auxrdata = 8'($urandom);
        end else begin
          engCode = (engScript.size() > 0) ? engScript.pop_front() : 0;
          auxrdata = engData;
        end
        auxack = (engCode != 1);
        auxerr = (engCode != 0);
        engLog.push_back('{engCode, auxrdata});
        if (auxerr && mErrcnt != 16'hFFFF) mErrcnt = mErrcnt + 16'd1;
        engActive = 1'b0;
      end else begin
        engCnt--;
      end
    end
  end

  // Protocol monitor: logs each attempt, enforces the idle gap and response exclusivity,
  // and drives the reference model during the random phase.
  always @(negedge clk) begin
    if (!resetn) begin
      prevAuxreq = 1'b0; lowRun = 0; sawCompletion = 1'b0; mInTxn = 1'b0;
    end else begin
      if (auxreq && !prevAuxreq) begin
        if (sawCompletion) checkOutput("min_gap", lowRun >= TB_GAP, 1);
        ownerLog.push_back(owner);
        addrLog.push_back(auxaddr);
        wdataLog.push_back(auxwdata);
        wrLog.push_back(auxwr);
        gapLog.push_back(lowRun);
        riseCycleLog.push_back(cycleCnt);
        if (modelOn) begin
          if (!mInTxn) begin
            mOwner = (sReq0 && sReq1) ? ~mLast : sReq1;
            mLast  = mOwner;
            mInTxn = 1'b1;
          end
          checkOutput("rnd_owner", owner, mOwner);
        end
        lowRun = 0;
      end
      if (!auxreq && prevAuxreq) sawCompletion = 1'b1;
      if (!auxreq) lowRun++;
      if (r0ack || r0err || r1ack || r1err) begin
        checkOutput("resp_onehot", $countones({r0ack, r0err, r1ack, r1err}), 1);
        if (r0ack) respAckCnt[0]++;
        if (r1ack) respAckCnt[1]++;
        if (r0err) respErrCnt[0]++;
        if (r1err) respErrCnt[1]++;
        if (modelOn) begin
          modelCompletion();
          mInTxn = 1'b0;
        end
      end
      prevAuxreq = auxreq;
    end
  end

  task automatic applyStimulus(input int idx, input vec_t v);
    int    res, start, a0, e0, o0;
    string pfx;
    pfx = $sformatf("vec%0d", idx);
    engScript.delete();
    if (v.both) engScript.push_back(2);
    else for (int i = 0; i < v.nErr; i++) engScript.push_back(1);
    engLatency = v.lat;
    engData    = v.engData;
    start = ownerLog.size();
    a0 = respAckCnt[v.port];
    e0 = respErrCnt[v.port];
    o0 = respAckCnt[1 - v.port] + respErrCnt[1 - v.port];
    portTxn(v.port, v.addr, v.wdata, v.wr, res);
    repeat (TB_GAP + 3) @(negedge clk);
    checkOutput({pfx, "_result"}, res, v.expAck ? 0 : 1);
    checkOutput({pfx, "_acks"}, respAckCnt[v.port] - a0, v.expAck);
    checkOutput({pfx, "_errs"}, respErrCnt[v.port] - e0, v.expErr);
    checkOutput({pfx, "_other_port"}, respAckCnt[1 - v.port] + respErrCnt[1 - v.port] - o0, 0);
    checkOutput({pfx, "_attempts"}, ownerLog.size() - start, v.expAttempts);
    if (ownerLog.size() > start)
      checkOutput({pfx, "_latency"}, riseCycleLog[start] - lastReqCycle[v.port], 1);
    for (int i = start; i < ownerLog.size(); i++) begin
      checkOutput({pfx, "_owner"}, ownerLog[i], v.port);
      checkOutput({pfx, "_addr"}, addrLog[i], v.addr);
      checkOutput({pfx, "_wdata"}, wdataLog[i], v.wdata);
      checkOutput({pfx, "_wr"}, wrLog[i], v.wr);
      if (i > start) checkOutput({pfx, "_retry_gap"}, gapLog[i], TB_GAP);
    end
    checkOutput({pfx, "_rdata"}, v.port == 1 ? r1rdata : r0rdata, v.expRdata);
    checkOutput({pfx, "_errcnt"}, errcnt, v.expErrcnt);
  endtask

  task automatic randomPort(input int port, input int n);
    int res;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      repeat ($urandom_range(0, 6)) @(negedge clk);
      portTxn(port, 20'($urandom), 8'($urandom), 1'($urandom), res);
      checkOutput("rnd_timeout", res == 2, 0);
      if (res == 2) break;
    end
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int   res0, res1, start;
    logic expOrder[4];

    vecs[0] = '{1, 20'h00100, 8'h00, 1'b0, 0, 1'b0, 2, 8'hA5, 1, 0, 1, 16'd0,  8'hA5};
    vecs[1] = '{0, 20'h00200, 8'h3C, 1'b1, 2, 1'b0, 1, 8'h5A, 1, 0, 3, 16'd2,  8'h5A};
    vecs[2] = '{1, 20'h00300, 8'h00, 1'b0, 4, 1'b0, 0, 8'hEE, 0, 1, 4, 16'd6,  8'hA5};
    vecs[3] = '{0, 20'h80001, 8'hC3, 1'b1, 3, 1'b0, 3, 8'h11, 1, 0, 4, 16'd9,  8'h11};
    vecs[4] = '{1, 20'hFFFFF, 8'h00, 1'b0, 0, 1'b1, 1, 8'h42, 1, 0, 1, 16'd10, 8'h42};
    vecs[5] = '{0, 20'h00000, 8'hFF, 1'b1, 0, 1'b0, 0, 8'h99, 1, 0, 1, 16'd10, 8'h99};

    resetn = 1'b0;
    clearInputs();
    repeat (2) @(negedge clk);
    checkOutput("rst_auxreq", auxreq, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_owner", owner, 0);
    checkOutput("rst_errcnt", errcnt, 0);
    checkOutput("rst_acks", {r0ack, r0err, r1ack, r1err}, 0);
    checkOutput("rst_rdata", {r0rdata, r1rdata}, 0);
    checkOutput("rst_auxaddr", auxaddr, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Simultaneous requests after reset, each port re-requesting after its ack.
    expOrder = '{1'b0, 1'b1, 1'b0, 1'b1};
    start = ownerLog.size();
    fork
      begin
        portTxn(0, 20'h00010, 8'h01, 1'b1, res0);
        @(negedge clk);
        portTxn(0, 20'h00011, 8'h02, 1'b1, res0);
      end
      begin
        portTxn(1, 20'h00020, 8'h03, 1'b1, res1);
        @(negedge clk);
        portTxn(1, 20'h00021, 8'h04, 1'b1, res1);
      end
    join
    checkOutput("rr_res", {res0[1:0], res1[1:0]}, 0);
    checkOutput("rr_count", ownerLog.size() - start, 4);
    for (int i = 0; i < 4; i++)
      if (start + i < ownerLog.size()) checkOutput("rr_order", ownerLog[start + i], expOrder[i]);
    repeat (TB_GAP + 3) @(negedge clk);

    // Port 0 locks for three writes while port 1 keeps requesting.
    start = ownerLog.size();
    fork
      begin
        r0lock = 1'b1;
        for (int k = 0; k < 3; k++) begin
          portTxn(0, 20'h00400 + 20'(k), 8'h10 + 8'(k), 1'b1, res0);
          if (k < 2) @(negedge clk);
        end
        r0lock = 1'b0;
      end
      portTxn(1, 20'h00500, 8'h00, 1'b0, res1);
    join
    checkOutput("lock_res", {res0[1:0], res1[1:0]}, 0);
    checkOutput("lock_count", ownerLog.size() - start, 4);
    for (int i = 0; i < 4; i++)
      if (start + i < ownerLog.size()) checkOutput("lock_order", ownerLog[start + i], i == 3);
    repeat (TB_GAP + 3) @(negedge clk);

    resetDut();
    for (int i = 0; i < 6; i++) applyStimulus(i, vecs[i]);

    resetDut();
    engLog.delete();
    mErrcnt = 16'd0;
    mLast   = 1'b1;
    engMode = 1'b1;
    modelOn = 1'b1;
    fork
      randomPort(0, 25);
      randomPort(1, 25);
    join
    repeat (TB_GAP + 8) @(negedge clk);
    modelOn = 1'b0;
    engMode = 1'b0;

    // Reset while a transaction is on the wire.
    resetDut();
    engLatency = 20;
    setReq(1, 1'b1, 20'h00700, 8'h00, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (auxreq) break;
    end
    checkOutput("rstmid_pre_auxreq", auxreq, 1);
    resetn = 1'b0;
    setReq(1, 1'b0, 20'h00700, 8'h00, 1'b0);
    #1;
    checkOutput("rstmid_auxreq", auxreq, 0);
    checkOutput("rstmid_busy", busy, 0);
    checkOutput("rstmid_owner", owner, 0);
    checkOutput("rstmid_acks", {r0ack, r0err, r1ack, r1err}, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    engLatency = 1;
    @(negedge clk);
    start = ownerLog.size();
    fork
      portTxn(0, 20'h00800, 8'h00, 1'b0, res0);
      portTxn(1, 20'h00900, 8'h00, 1'b0, res1);
    join
    checkOutput("rstmid_post_res", {res0[1:0], res1[1:0]}, 0);
    checkOutput("rstmid_post_count", ownerLog.size() - start, 2);
    if (ownerLog.size() > start) checkOutput("rstmid_first_grant", ownerLog[start], 0);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
